program_loader: RTL and testbench
=================================

# program_loader

Boot-time program loader sitting directly upstream of the multicycle processor's unified instruction/data memory. It holds the processor in reset, accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian words and writes them into consecutive memory words. It then releases the processor to fetch from the base address.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word-aligned.
- MAX_WORDS, 64: capacity limit in words, 1..65535.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_last  input  1  qualifies the final data byte of the image; sampled with in_data.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_adr  output  32  memory write byte address.
- mem_wd  output  32  memory write data.
- mem_we  output  1  memory write strobe; maps to the memory MemWrite input.
- cpu_hold  output  1  active-high reset to the processor; 1 while loading or in error.
- done  output  1  image loaded; processor running.
- error  output  1  sticky load failure.
- word_count  output  16  number of words written so far.

## Operation
- A byte is accepted only on a rising edge with in_valid=1 and in_ready=1. in_valid with in_ready=0 is ignored.
- The first accepted byte of a word goes to bits [31:24], the second to [23:16], the third to [15:8] and the fourth to [7:0].
- The states are LOAD, WRITE, CHECK (macro only), DONE and ERR.
- LOAD:
  - in_ready=1.
  - A 2-bit byte index counts accepted bytes.
  - On the 4th byte, go to WRITE and latch in_last into last_f.
  - If in_last=1 on byte index 0, 1 or 2, go to ERR. Nothing is written.
- WRITE (exactly 1 cycle):
  - mem_we=1, in_ready=0.
  - mem_adr = BASE_ADDR + 4*word_count, with 32-bit wrap.
  - mem_wd = the assembled word.
  - word_count increments at the end of the cycle.
  - Next state:
    - last_f=1: DONE, or CHECK when the macro is defined.
    - Else, if the incremented count equals MAX_WORDS: ERR.
    - Else: LOAD, with the byte index at 0.
- DONE:
  - cpu_hold=0, done=1, in_ready=0, mem_we=0.
  - Terminal until reset.
- ERR:
  - error=1, cpu_hold=1, in_ready=0, mem_we=0.
  - Terminal until reset.
- word_count freezes in DONE and ERR.
- Outside WRITE, mem_adr and mem_wd hold their last values. mem_we=0.

## Timing
- Reset (asynchronous, immediate on reset=0) forces:
  - state LOAD, byte index 0, word_count 0;
  - mem_adr=BASE_ADDR, mem_wd=0, mem_we=0;
  - cpu_hold=1, done=0, error=0.
- in_ready=0 while reset=0. in_ready=1 in the first cycle after release.
- All outputs are Moore (registered state decode). in_ready has no combinational path from in_valid.
- Minimum of 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- done and cpu_hold=0 appear in the cycle after the final WRITE (or after CHECK).
- Reset during loading aborts immediately. Words already written remain in memory. The loader restarts at BASE_ADDR.
- A byte presented with in_valid during WRITE waits. It is accepted in the following LOAD cycle, provided the source holds it.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The loader keeps a running 8-bit XOR of all accepted data bytes.
  - After the final WRITE it enters CHECK with in_ready=1 and accepts exactly one checksum byte. in_last is ignored for this byte.
  - Byte equals the XOR: go to DONE.
  - Byte differs: go to ERR.
- LOADER_CHECKSUM_EN undefined:
  - There is no CHECK state and no XOR register.
  - The final WRITE goes directly to DONE.

## Test plan
- Reset check:
  - Stimulus: hold reset=0, then release.
  - Required during reset: in_ready=0, cpu_hold=1, done=0, error=0, mem_we=0, word_count=0, mem_adr=0.
  - Required the cycle after release: in_ready=1.
- Two-word load:
  - Stimulus: bytes 20 08 00 05, then AC 08 00 00, with in_last set on the final byte.
  - Required: mem_we pulses write 32'h20080005 at address 0x0 and 32'hAC080000 at address 0x4.
  - Required: word_count=2; done=1 and cpu_hold=0 the cycle after the second write.
- Backpressure and gaps:
  - Stimulus: random in_valid gaps; in_valid held high through a WRITE cycle.
  - Required: no byte is lost or duplicated; the written words equal those in the two-word load.
- Partial-word error:
  - Stimulus: in_last asserted on the 2nd byte.
  - Required: error=1 next cycle, mem_we never pulses, cpu_hold stays 1.
  - Required: a subsequent reset returns the loader to the reset state.
- Overflow:
  - Stimulus: MAX_WORDS=2; three words sent, last flag only on the third.
  - Required: two writes occur, then error=1; the third word is not accepted.
- Checksum (LOADER_CHECKSUM_EN defined):
  - Stimulus: image 20 08 00 05 with checksum 2D.
  - Required: done=1.
  - Stimulus: same image with checksum 2C.
  - Required: error=1, cpu_hold=1.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time loader: packs a big-endian byte stream into 32-bit words, writes them to memory,
// then releases the processor. Optional trailing XOR checksum under `LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        StLoad  = 3'd0,
        StWrite = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        StCheck = 3'd2,
`endif
        StDone  = 3'd3,
        StErr   = 3'd4
    } state_e;

    localparam logic [15:0] MaxWords = 16'(MAX_WORDS);

    state_e      state_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] word_q;
    logic        last_f_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    logic        accept;
    logic [15:0] count_inc;
    logic [31:0] wr_adr;

    // in_ready is a register, so acceptance never depends combinationally on in_valid.
    assign accept    = in_valid && in_ready;
    assign count_inc = word_count + 16'd1;
    assign wr_adr    = BASE_ADDR + {14'd0, word_count, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StLoad;
            byte_idx_q <= 2'd0;
            word_q     <= 24'd0;
            last_f_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= 8'd0;
`endif
            in_ready   <= 1'b0;
            mem_adr    <= BASE_ADDR;
            mem_wd     <= 32'd0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 16'd0;
        end else begin
            mem_we <= 1'b0;
            case (state_q)
                StLoad: begin
                    // Also covers the first cycle after reset release.
                    in_ready <= 1'b1;
                    if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ in_data;
`endif
                        if (byte_idx_q == 2'd3) begin
                            state_q    <= StWrite;
                            in_ready   <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_adr    <= wr_adr;
                            mem_wd     <= {word_q, in_data};
                            last_f_q   <= in_last;
                            byte_idx_q <= 2'd0;
                        end else if (in_last) begin
                            // Image ends mid-word: nothing of this word is written.
                            state_q  <= StErr;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            word_q     <= {word_q[15:0], in_data};
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                StWrite: begin
                    word_count <= count_inc;
                    if (last_f_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q  <= StCheck;
                        in_ready <= 1'b1;
`else
                        state_q  <= StDone;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else if (count_inc == MaxWords) begin
                        state_q <= StErr;
                        error   <= 1'b1;
                    end else begin
                        state_q  <= StLoad;
                        in_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCheck: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == xor_q) begin
                            state_q  <= StDone;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                StDone: begin
                    in_ready <= 1'b0;
                end
                StErr: begin
                    in_ready <= 1'b0;
                end
                default: begin
                    state_q  <= StErr;
                    in_ready <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and randomized image loads compared
// against a byte-queue reference model; a second instance with MAX_WORDS=2 covers overflow.
module tb_program_loader;

    logic        clk;
    logic        rst_main;
    logic        rst_ovf;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;

    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_adr, mem_wd;
    logic [15:0] word_count;

    logic        o_in_ready, o_mem_we, o_cpu_hold, o_done, o_error;
    logic [31:0] o_mem_adr, o_mem_wd;
    logic [15:0] o_word_count;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    bit          sel_ovf   = 1'b0;
    bit          cks_flip  = 1'b0;
    bit          ok;
    logic [7:0]  img_q[$];
    logic [31:0] wa_q[$], wd_q[$], owa_q[$], owd_q[$];

    program_loader dut (
        .clk       (clk),
        .reset     (rst_main),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    program_loader #(
        .MAX_WORDS(2)
    ) dut_ovf (
        .clk       (clk),
        .reset     (rst_ovf),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (o_in_ready),
        .mem_adr   (o_mem_adr),
        .mem_wd    (o_mem_wd),
        .mem_we    (o_mem_we),
        .cpu_hold  (o_cpu_hold),
        .done      (o_done),
        .error     (o_error),
        .word_count(o_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: sees the pre-edge register values at each rising edge.
    always @(posedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_adr);
            wd_q.push_back(mem_wd);
        end
        if (o_mem_we) begin
            owa_q.push_back(o_mem_adr);
            owd_q.push_back(o_mem_wd);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input bit gap, output bit acc);
        int k;
        @(negedge clk);
        k = gap ? $urandom_range(0, 3) : 0;
        if (k > 0) begin
            in_valid = 1'b0;
            repeat (k) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        acc      = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(posedge clk);
            if (sel_ovf ? o_in_ready : in_ready) acc = 1'b1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic reset_main();
        @(negedge clk);
        rst_main = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        rst_main = 1'b1;
    endtask

    function automatic logic [7:0] model_xor();
        logic [7:0] x = 8'd0;
        foreach (img_q[i]) x = x ^ img_q[i];
        return x;
    endfunction

    function automatic logic [31:0] model_word(input int i);
        return (32'(img_q[4*i]) << 24) | (32'(img_q[4*i+1]) << 16) |
               (32'(img_q[4*i+2]) << 8) | 32'(img_q[4*i+3]);
    endfunction

    // Feeds img_q with in_last on the final byte; no gap before byte 0 of a word so the
    // source holds in_valid high through the preceding WRITE cycle.
    task automatic load_image(input bit gaps);
        bit a;
        for (int i = 0; i < img_q.size(); i++) begin
            send_byte(img_q[i], (i == img_q.size() - 1), gaps && (i % 4 != 0), a);
            chk("byte_accept", 32'(a), 32'd1);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(model_xor() ^ {7'd0, cks_flip}, 1'b0, gaps, a);
        chk("cks_accept", 32'(a), 32'd1);
`endif
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_image(input string tag);
        int nw = img_q.size() / 4;
        chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            chk({tag, "_adr"}, wa_q[i], 32'(4 * i));
            chk({tag, "_wd"}, wd_q[i], model_word(i));
        end
        chk({tag, "_word_count"}, 32'(word_count), 32'(nw));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        rst_main = 1'b0;
        rst_ovf  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        @(negedge clk);
        rst_main = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed two-word load with exact write/done timing
        reset_main();
        img_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            send_byte(img_q[i], (i == 7), 1'b0, ok);
            chk("dir_accept", 32'(ok), 32'd1);
            if (i == 3 || i == 7) begin
                #1;
                chk("dir_mem_we", 32'(mem_we), 32'd1);
                chk("dir_mem_adr", mem_adr, (i == 3) ? 32'h0 : 32'h4);
                chk("dir_mem_wd", mem_wd, (i == 3) ? 32'h2008_0005 : 32'hAC08_0000);
                chk("dir_in_ready_wr", 32'(in_ready), 32'd0);
                chk("dir_done_early", 32'(done), 32'd0);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(model_xor(), 1'b0, 1'b0, ok);
        chk("dir_cks_accept", 32'(ok), 32'd1);
`endif
        idle();
        @(posedge clk);
        #1;
        chk("dir_done", 32'(done), 32'd1);
        chk("dir_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("dir_mem_we_off", 32'(mem_we), 32'd0);
        check_image("dir");

        // Backpressure and gaps, same image
        reset_main();
        load_image(1'b1);
        check_image("bp");

        // Randomized images
        for (int it = 0; it < 6; it++) begin
            int nw = $urandom_range(1, 6);
            reset_main();
            img_q.delete();
            for (int j = 0; j < 4 * nw; j++) img_q.push_back(8'($urandom_range(0, 255)));
            load_image(1'b1);
            check_image("rnd");
        end

        // Reset mid-load restarts at the base address
        reset_main();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(i + 1), 1'b0, 1'b0, ok);
        end
        @(negedge clk);
        rst_main = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("abort_word_count", 32'(word_count), 32'd0);
        chk("abort_mem_adr", mem_adr, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        rst_main = 1'b1;
        wa_q.delete();
        wd_q.delete();
        img_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        load_image(1'b0);
        check_image("abort");

        // Partial-word error
        reset_main();
        send_byte(8'h11, 1'b0, 1'b0, ok);
        send_byte(8'h22, 1'b1, 1'b0, ok);
        chk("part_accept", 32'(ok), 32'd1);
        #1;
        chk("part_error", 32'(error), 32'd1);
        chk("part_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("part_in_ready", 32'(in_ready), 32'd0);
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("part_error_sticky", 32'(error), 32'd1);
        chk("part_done", 32'(done), 32'd0);
        chk("part_nwrites", 32'(wa_q.size()), 32'd0);
        chk("part_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_main = 1'b0;
        #1;
        chk("part_rst_error", 32'(error), 32'd0);
        chk("part_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("part_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_main = 1'b1;
        @(posedge clk);
        #1;
        chk("part_rel_in_ready", 32'(in_ready), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good and bad
        img_q = '{8'h20, 8'h08, 8'h00, 8'h05};
        chk("cks_model", 32'(model_xor()), 32'h2D);
        reset_main();
        cks_flip = 1'b0;
        load_image(1'b0);
        check_image("cks_good");
        reset_main();
        cks_flip = 1'b1;
        load_image(1'b0);
        chk("cks_bad_error", 32'(error), 32'd1);
        chk("cks_bad_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("cks_bad_done", 32'(done), 32'd0);
        cks_flip = 1'b0;
`endif

        // Overflow on the MAX_WORDS=2 instance
        @(negedge clk);
        rst_main = 1'b0;
        owa_q.delete();
        owd_q.delete();
        rst_ovf = 1'b1;
        sel_ovf = 1'b1;
        img_q.delete();
        for (int j = 0; j < 12; j++) img_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 8; i++) begin
            send_byte(img_q[i], 1'b0, 1'b1, ok);
            chk("ovf_accept", 32'(ok), 32'd1);
        end
        send_byte(img_q[8], 1'b0, 1'b0, ok);
        chk("ovf_third_rejected", 32'(ok), 32'd0);
        idle();
        #1;
        chk("ovf_nwrites", 32'(owa_q.size()), 32'd2);
        for (int i = 0; i < 2 && i < owa_q.size(); i++) begin
            chk("ovf_adr", owa_q[i], 32'(4 * i));
            chk("ovf_wd", owd_q[i], model_word(i));
        end
        chk("ovf_error", 32'(o_error), 32'd1);
        chk("ovf_cpu_hold", 32'(o_cpu_hold), 32'd1);
        chk("ovf_done", 32'(o_done), 32'd0);
        chk("ovf_word_count", 32'(o_word_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
